mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-requester arbiter that shares the single cache-line memory bus between the instruction-cache miss port (I) and the data-cache miss port (D). Each side speaks the line-transfer handshake used by the caches: request / reqack / wrenable / addr / 512-bit wdata / 512-bit rdata / done. The block sits between both caches and the memory interface. It serialises transactions so that exactly one line transfer is outstanding at any time.

## Interface

Parameters:
- `AW`, 64: address width.
- `LW`, 512: line width in bits (64 bytes).

Ports:
- `clk` in 1: clock; all logic samples on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `i_request` in 1: I-side request; held high until `i_reqack`.
- `i_wrenable` in 1: I-side write flag, held with `i_request`; normally 0.
- `i_addr` in AW: I-side line address; bits [5:0] are 0.
- `i_wdata` in LW: I-side write line.
- `i_reqack` out 1: one-cycle pulse; the I-side request has been accepted.
- `i_rdata` out LW: read line returned to the I side.
- `i_done` out 1: one-cycle pulse; the I-side transfer is complete and `i_rdata` is valid.
- `d_request`, `d_wrenable`, `d_addr`, `d_wdata`, `d_reqack`, `d_rdata`, `d_done`: same as the I side, for the D side.
- `bus_request` out 1: request to memory; held until `bus_reqack`.
- `bus_wrenable` out 1: write flag of the granted transaction.
- `bus_addr` out AW: address of the granted transaction.
- `bus_wdata` out LW: write line of the granted transaction.
- `bus_reqack` in 1: memory has accepted the request.
- `bus_rdata` in LW: read line from memory, valid with `bus_done`.
- `bus_done` in 1: one-cycle pulse; the memory transfer is complete.

## Operation

States: IDLE, ISSUE, WAIT, DONE. A one-bit register `owner` (0 = I, 1 = D) records the granted side.

- **IDLE**
  - If any request is high, select a winner (see Configuration).
  - Latch the winner's addr, wdata and wrenable into the `bus_*` registers.
  - Set `bus_request` to 1, set `owner`, and go to ISSUE.
  - With no request, the `bus_*` outputs are driven to 0.
- **ISSUE**
  - Hold `bus_request` and all `bus_*` outputs stable.
  - On `bus_reqack`: set `bus_request` to 0, pulse the owner's reqack in the next cycle, and go to WAIT.
- **WAIT**
  - On `bus_done`: register `bus_rdata` into the owner's rdata, pulse the owner's done in the next cycle, and go to DONE.
  - The non-owner's rdata holds its previous value.
- **DONE**
  - Dead cycle; set `bus_addr`, `bus_wdata` and `bus_wrenable` to 0; go to IDLE.
  - This cycle guarantees that the previous owner's request has fallen before re-arbitration.

General rules:
- A requester whose request is not granted keeps it high and is served later; it receives no pulse.
- `bus_reqack` or `bus_done` arriving in a state other than the one that expects it is ignored.
- If `bus_reqack` and `bus_done` are asserted in the same ISSUE cycle, only `bus_reqack` is taken; `bus_done` is taken only in WAIT.
- Requester inputs are sampled only in IDLE. Changes in any other state have no effect on the transaction in flight.
- Reset mid-transaction:
  - The transaction is abandoned and the state returns to IDLE.
  - The memory side must itself be reset.
  - Requesters re-issue.

## Timing

- Reset values:
  - state IDLE, `owner` 0, and the round-robin last-grant bit 0.
  - All outputs 0, including both rdata buses and all pulses.
- Grant latency: a request visible at edge N produces `bus_request` high after edge N.
- Acknowledge latency: `bus_reqack` sampled at edge T produces the owner's reqack high in cycle T+1, for one cycle.
- Completion latency: `bus_done` sampled at edge U produces the owner's done high and its rdata valid in cycle U+1, for one cycle.
- Back-to-back throughput: a second pending request produces `bus_request` 2 cycles after the first done pulse (through DONE, then IDLE).
- Minimum transaction is 4 arbiter cycles plus memory latency.
- Pulses are never asserted on both sides in the same cycle.

## Configuration

- `MEM_ARB_RR_EN` defined: round-robin arbitration.
  - When both sides request in IDLE, grant the side not granted last.
  - The last-grant bit updates on every grant.
- `MEM_ARB_RR_EN` undefined: fixed priority.
  - D wins whenever `d_request` is high.
  - I is granted only when `d_request` is low.
  - The last-grant bit is absent.

## Test plan

- **Single I read.** Stimulus: `i_request`, addr 0x1000; `bus_reqack` 2 cycles after `bus_request`; `bus_done` 3 cycles later with `bus_rdata` = pattern A. Required: `bus_addr` is 0x1000 and `bus_wrenable` is 0; `i_reqack` pulses once; `i_done` pulses once with `i_rdata` = A; the D side stays 0.
- **D write.** Stimulus: `d_request` with `d_wrenable` = 1, addr 0x2040, `d_wdata` = B. Required: `bus_wrenable` is 1 and `bus_wdata` = B while `bus_request` is high; `d_done` pulses once.
- **Simultaneous requests, `MEM_ARB_RR_EN` defined.** Stimulus: both sides hold requests continuously from reset. Required: grant order D? no — grant order is I, D, I, D (last-grant bit starts at 0, so I is granted first); the gap from each done pulse to the next `bus_request` is 2 cycles.
- **Simultaneous requests, `MEM_ARB_RR_EN` undefined.** Stimulus: both sides request, and D re-requests immediately after each `d_done`. Required: the I side is never granted while `d_request` is high.
- **Earliest memory response.** Stimulus: `bus_reqack` and `bus_done` on consecutive cycles. Required: reqack and done pulses are correctly separated; the stale request is not re-granted.
- **Mid-transaction reset.** Stimulus: assert `reset_n` = 0 in WAIT. Required: all outputs go to 0 immediately (asynchronously); after release, a new request is granted from IDLE.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_arbiter_if
// Line-transfer handshake shared by the cache miss ports and the memory bus.
// The same bundle describes both ends of a link:
//   master : drives request / wrenable / addr / wdata, receives reqack / rdata / done
//   slave  : receives request / wrenable / addr / wdata, drives reqack / rdata / done
// Signals:
//   request  - transfer request, held until reqack
//   wrenable - 1 = line write, 0 = line read
//   addr     - line address (AW bits, low 6 bits zero)
//   wdata    - write line (LW bits)
//   reqack   - one-cycle pulse, request accepted
//   rdata    - read line, valid with done
//   done     - one-cycle pulse, transfer complete
// -----------------------------------------------------------------------------
interface mem_arbiter_if #(
  parameter int AW = 64,
  parameter int LW = 512
);
  logic          request;
  logic          wrenable;
  logic [AW-1:0] addr;
  logic [LW-1:0] wdata;
  logic          reqack;
  logic [LW-1:0] rdata;
  logic          done;

  modport master (
    output request, wrenable, addr, wdata,
    input  reqack, rdata, done
  );

  modport slave (
    input  request, wrenable, addr, wdata,
    output reqack, rdata, done
  );
endinterface

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Shares the single cache-line memory bus between the instruction-cache miss
// port (I) and the data-cache miss port (D). Exactly one line transfer is in
// flight at a time: IDLE -> ISSUE -> WAIT -> DONE -> IDLE.
//
// Ports:
//   clk      - rising-edge clock
//   reset_n  - asynchronous active-low reset
//   i_side   - I-cache miss port (slave end of mem_arbiter_if)
//   d_side   - D-cache miss port (slave end of mem_arbiter_if)
//   bus_side - memory bus (master end of mem_arbiter_if)
//
// Configuration macro MEM_ARB_RR_EN:
//   defined   - round-robin between I and D when both request
//   undefined - fixed priority, D wins whenever it requests
//
// All outputs are registered; every pulse lasts exactly one cycle.
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int AW = 64,
  parameter int LW = 512
) (
  input  logic           clk,
  input  logic           reset_n,
  mem_arbiter_if.slave   i_side,
  mem_arbiter_if.slave   d_side,
  mem_arbiter_if.master  bus_side
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;

  // 0 = I owns the bus, 1 = D owns the bus
  logic          r_owner;
  logic          w_owner_nxt;

  logic          r_bus_request;
  logic          r_bus_wrenable;
  logic [AW-1:0] r_bus_addr;
  logic [LW-1:0] r_bus_wdata;
  logic          w_bus_request_nxt;
  logic          w_bus_wrenable_nxt;
  logic [AW-1:0] w_bus_addr_nxt;
  logic [LW-1:0] w_bus_wdata_nxt;

  logic          r_i_reqack;
  logic          r_d_reqack;
  logic          r_i_done;
  logic          r_d_done;
  logic [LW-1:0] r_i_rdata;
  logic [LW-1:0] r_d_rdata;
  logic          w_i_reqack_nxt;
  logic          w_d_reqack_nxt;
  logic          w_i_done_nxt;
  logic          w_d_done_nxt;
  logic [LW-1:0] w_i_rdata_nxt;
  logic [LW-1:0] w_d_rdata_nxt;

  logic          w_any_req;
  logic          w_grant_d;

  assign w_any_req = i_side.request | d_side.request;

`ifdef MEM_ARB_RR_EN
  // Tie-break bit: 0 favours I, 1 favours D. It is loaded with the inverse of
  // every grant, so on a tie the side that was not granted last wins. Reset
  // value 0 therefore grants I first.
  logic r_rr_last;

  assign w_grant_d = d_side.request & (~i_side.request | r_rr_last);

  // Round-robin tie-break register, updated on every grant.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rr_last <= 1'b0;
    end else if ((r_state == ST_IDLE) && w_any_req) begin
      r_rr_last <= ~w_grant_d;
    end else begin
      r_rr_last <= r_rr_last;
    end
  end
`else
  // Fixed priority: D wins whenever it requests.
  assign w_grant_d = d_side.request;
`endif

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and next-output logic; bus_reqack/bus_done are only honoured
  // in the state that expects them, so a done seen in ISSUE is dropped.
  always_comb begin
    w_state_nxt        = r_state;
    w_owner_nxt        = r_owner;
    w_bus_request_nxt  = r_bus_request;
    w_bus_wrenable_nxt = r_bus_wrenable;
    w_bus_addr_nxt     = r_bus_addr;
    w_bus_wdata_nxt    = r_bus_wdata;
    w_i_reqack_nxt     = 1'b0;
    w_d_reqack_nxt     = 1'b0;
    w_i_done_nxt       = 1'b0;
    w_d_done_nxt       = 1'b0;
    w_i_rdata_nxt      = r_i_rdata;
    w_d_rdata_nxt      = r_d_rdata;

    case (r_state)
      ST_IDLE: begin
        if (w_any_req) begin
          w_owner_nxt       = w_grant_d;
          w_bus_request_nxt = 1'b1;
          w_state_nxt       = ST_ISSUE;
          if (w_grant_d) begin
            w_bus_wrenable_nxt = d_side.wrenable;
            w_bus_addr_nxt     = d_side.addr;
            w_bus_wdata_nxt    = d_side.wdata;
          end else begin
            w_bus_wrenable_nxt = i_side.wrenable;
            w_bus_addr_nxt     = i_side.addr;
            w_bus_wdata_nxt    = i_side.wdata;
          end
        end else begin
          w_bus_request_nxt  = 1'b0;
          w_bus_wrenable_nxt = 1'b0;
          w_bus_addr_nxt     = {AW{1'b0}};
          w_bus_wdata_nxt    = {LW{1'b0}};
        end
      end

      ST_ISSUE: begin
        if (bus_side.reqack) begin
          w_bus_request_nxt = 1'b0;
          w_state_nxt       = ST_WAIT;
          if (r_owner) begin
            w_d_reqack_nxt = 1'b1;
          end else begin
            w_i_reqack_nxt = 1'b1;
          end
        end else begin
          w_state_nxt = ST_ISSUE;
        end
      end

      ST_WAIT: begin
        if (bus_side.done) begin
          w_state_nxt = ST_DONE;
          if (r_owner) begin
            w_d_rdata_nxt = bus_side.rdata;
            w_d_done_nxt  = 1'b1;
          end else begin
            w_i_rdata_nxt = bus_side.rdata;
            w_i_done_nxt  = 1'b1;
          end
        end else begin
          w_state_nxt = ST_WAIT;
        end
      end

      // Dead cycle: lets the finished requester drop its request before the
      // next arbitration, so a stale request is never granted twice.
      ST_DONE: begin
        w_bus_request_nxt  = 1'b0;
        w_bus_wrenable_nxt = 1'b0;
        w_bus_addr_nxt     = {AW{1'b0}};
        w_bus_wdata_nxt    = {LW{1'b0}};
        w_state_nxt        = ST_IDLE;
      end

      default: begin
        w_bus_request_nxt  = 1'b0;
        w_bus_wrenable_nxt = 1'b0;
        w_bus_addr_nxt     = {AW{1'b0}};
        w_bus_wdata_nxt    = {LW{1'b0}};
        w_state_nxt        = ST_IDLE;
      end
    endcase
  end

  // Owner, bus and requester-facing output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_owner        <= 1'b0;
      r_bus_request  <= 1'b0;
      r_bus_wrenable <= 1'b0;
      r_bus_addr     <= {AW{1'b0}};
      r_bus_wdata    <= {LW{1'b0}};
      r_i_reqack     <= 1'b0;
      r_d_reqack     <= 1'b0;
      r_i_done       <= 1'b0;
      r_d_done       <= 1'b0;
      r_i_rdata      <= {LW{1'b0}};
      r_d_rdata      <= {LW{1'b0}};
    end else begin
      r_owner        <= w_owner_nxt;
      r_bus_request  <= w_bus_request_nxt;
      r_bus_wrenable <= w_bus_wrenable_nxt;
      r_bus_addr     <= w_bus_addr_nxt;
      r_bus_wdata    <= w_bus_wdata_nxt;
      r_i_reqack     <= w_i_reqack_nxt;
      r_d_reqack     <= w_d_reqack_nxt;
      r_i_done       <= w_i_done_nxt;
      r_d_done       <= w_d_done_nxt;
      r_i_rdata      <= w_i_rdata_nxt;
      r_d_rdata      <= w_d_rdata_nxt;
    end
  end

  assign bus_side.request  = r_bus_request;
  assign bus_side.wrenable = r_bus_wrenable;
  assign bus_side.addr     = r_bus_addr;
  assign bus_side.wdata    = r_bus_wdata;

  assign i_side.reqack = r_i_reqack;
  assign i_side.done   = r_i_done;
  assign i_side.rdata  = r_i_rdata;

  assign d_side.reqack = r_d_reqack;
  assign d_side.done   = r_d_done;
  assign d_side.rdata  = r_d_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Directed self-checking bench for mem_arbiter. The bench plays both caches
// and the memory. Outputs are sampled 1 ns after each rising edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mem_arbiter;
  localparam int AW = 64;
  localparam int LW = 512;

  logic clk;
  logic reset_n;

  int n_cmp = 0;
  int n_fail = 0;

  // pulse counters, sampled mid-cycle
  int cnt_i_ack  = 0;
  int cnt_d_ack  = 0;
  int cnt_i_done = 0;
  int cnt_d_done = 0;
  int cnt_both   = 0;

  logic [LW-1:0] pat_a, pat_b, pat_c, pat_d, pat_e, pat_f;
  logic [AW-1:0] addr_i, addr_d;

  mem_arbiter_if #(.AW(AW), .LW(LW)) i_bus ();
  mem_arbiter_if #(.AW(AW), .LW(LW)) d_bus ();
  mem_arbiter_if #(.AW(AW), .LW(LW)) m_bus ();

  mem_arbiter #(.AW(AW), .LW(LW)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_side   (i_bus),
    .d_side   (d_bus),
    .bus_side (m_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (i_bus.reqack) cnt_i_ack++;
    if (d_bus.reqack) cnt_d_ack++;
    if (i_bus.done) cnt_i_done++;
    if (d_bus.done) cnt_d_done++;
    if ((i_bus.reqack | i_bus.done) & (d_bus.reqack | d_bus.done)) cnt_both++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    i_bus.request = 1'b0; i_bus.wrenable = 1'b0; i_bus.addr = '0; i_bus.wdata = '0;
    d_bus.request = 1'b0; d_bus.wrenable = 1'b0; d_bus.addr = '0; d_bus.wdata = '0;
    m_bus.reqack = 1'b0; m_bus.done = 1'b0; m_bus.rdata = '0;
  endtask

  // Memory model: reqack ack_dly cycles after being called, done done_dly
  // cycles after reqack. Returns the {d,i} reqack pulses seen after reqack.
  task automatic mem_respond(input int ack_dly, input int done_dly, input logic [LW-1:0] rd,
                             input bit drop, output logic [1:0] obs);
    repeat (ack_dly) tick();
    m_bus.reqack = 1'b1;
    tick();
    m_bus.reqack = 1'b0;
    obs = {d_bus.reqack, i_bus.reqack};
    if (drop) begin
      if (obs[0]) i_bus.request = 1'b0;
      if (obs[1]) d_bus.request = 1'b0;
    end
    repeat (done_dly - 1) tick();
    m_bus.rdata = rd;
    m_bus.done  = 1'b1;
    tick();
    m_bus.done = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    clear_inputs();
    repeat (2) tick();
    n_cmp++; if ({m_bus.request, m_bus.wrenable, i_bus.reqack, i_bus.done, d_bus.reqack, d_bus.done} !== 6'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b expected %b",
        {m_bus.request, m_bus.wrenable, i_bus.reqack, i_bus.done, d_bus.reqack, d_bus.done}, 6'b0); end
    n_cmp++; if ((m_bus.addr !== '0) || (m_bus.wdata !== '0)) begin
      n_fail++; $display("FAIL reset_bus: got addr %h expected 0", m_bus.addr); end
    n_cmp++; if ((i_bus.rdata !== '0) || (d_bus.rdata !== '0)) begin
      n_fail++; $display("FAIL reset_rdata: got %h expected 0", i_bus.rdata | d_bus.rdata); end
    reset_n = 1'b1;
    tick();
    n_cmp++; if (m_bus.request !== 1'b0) begin
      n_fail++; $display("FAIL idle_no_req: got %b expected 0", m_bus.request); end
  endtask

  task automatic test_single_read();
    logic [1:0] obs;
    int a0, d0, da0, dd0;
    a0 = cnt_i_ack; d0 = cnt_i_done; da0 = cnt_d_ack; dd0 = cnt_d_done;
    i_bus.request = 1'b1; i_bus.wrenable = 1'b0; i_bus.addr = 64'h1000;
    tick();
    n_cmp++; if ({m_bus.request, m_bus.wrenable} !== 2'b10) begin
      n_fail++; $display("FAIL rd_grant: got %b expected %b", {m_bus.request, m_bus.wrenable}, 2'b10); end
    n_cmp++; if (m_bus.addr !== 64'h1000) begin
      n_fail++; $display("FAIL rd_addr: got %h expected %h", m_bus.addr, 64'h1000); end
    mem_respond(2, 3, pat_a, 1'b1, obs);
    n_cmp++; if (obs !== 2'b01) begin
      n_fail++; $display("FAIL rd_reqack: got %b expected %b", obs, 2'b01); end
    n_cmp++; if ({d_bus.done, i_bus.done} !== 2'b01) begin
      n_fail++; $display("FAIL rd_done: got %b expected %b", {d_bus.done, i_bus.done}, 2'b01); end
    n_cmp++; if (i_bus.rdata !== pat_a) begin
      n_fail++; $display("FAIL rd_rdata: got %h expected %h", i_bus.rdata, pat_a); end
    n_cmp++; if (d_bus.rdata !== '0) begin
      n_fail++; $display("FAIL rd_d_rdata: got %h expected 0", d_bus.rdata); end
    tick();
    n_cmp++; if ({m_bus.request, i_bus.done, (m_bus.addr != '0)} !== 3'b000) begin
      n_fail++; $display("FAIL rd_after_done: got %b expected 000", {m_bus.request, i_bus.done, (m_bus.addr != '0)}); end
    n_cmp++; if ({cnt_i_ack - a0, cnt_i_done - d0, cnt_d_ack - da0, cnt_d_done - dd0} !== {32'd1, 32'd1, 32'd0, 32'd0}) begin
      n_fail++; $display("FAIL rd_pulse_counts: got %0d %0d %0d %0d expected 1 1 0 0",
        cnt_i_ack - a0, cnt_i_done - d0, cnt_d_ack - da0, cnt_d_done - dd0); end
  endtask

  task automatic test_d_write();
    logic [1:0] obs;
    int dd0;
    dd0 = cnt_d_done;
    d_bus.request = 1'b1; d_bus.wrenable = 1'b1; d_bus.addr = 64'h2040; d_bus.wdata = pat_b;
    tick();
    n_cmp++; if ({m_bus.request, m_bus.wrenable} !== 2'b11) begin
      n_fail++; $display("FAIL wr_grant: got %b expected %b", {m_bus.request, m_bus.wrenable}, 2'b11); end
    // requester inputs changed after the grant must not reach the bus
    d_bus.addr = 64'h0; d_bus.wdata = pat_f; d_bus.wrenable = 1'b0;
    tick();
    n_cmp++; if ((m_bus.wdata !== pat_b) || (m_bus.addr !== 64'h2040) || (m_bus.wrenable !== 1'b1)) begin
      n_fail++; $display("FAIL wr_hold: got addr %h wr %b expected addr %h wr 1", m_bus.addr, m_bus.wrenable, 64'h2040); end
    mem_respond(1, 2, pat_c, 1'b1, obs);
    n_cmp++; if (obs !== 2'b10) begin
      n_fail++; $display("FAIL wr_reqack: got %b expected %b", obs, 2'b10); end
    n_cmp++; if ({d_bus.done, i_bus.done} !== 2'b10) begin
      n_fail++; $display("FAIL wr_done: got %b expected %b", {d_bus.done, i_bus.done}, 2'b10); end
    n_cmp++; if ((d_bus.rdata !== pat_c) || (i_bus.rdata !== pat_a)) begin
      n_fail++; $display("FAIL wr_rdata: got d %h expected %h", d_bus.rdata, pat_c); end
    tick();
    n_cmp++; if (cnt_d_done - dd0 !== 1) begin
      n_fail++; $display("FAIL wr_done_count: got %0d expected 1", cnt_d_done - dd0); end
  endtask

  task automatic test_stray_response();
    int a0;
    a0 = cnt_i_ack + cnt_d_ack + cnt_i_done + cnt_d_done;
    m_bus.reqack = 1'b1; m_bus.done = 1'b1;
    tick();
    m_bus.reqack = 1'b0; m_bus.done = 1'b0;
    tick();
    n_cmp++; if ((m_bus.request !== 1'b0) || (cnt_i_ack + cnt_d_ack + cnt_i_done + cnt_d_done - a0 !== 0)) begin
      n_fail++; $display("FAIL stray_idle: got req %b expected 0", m_bus.request); end
    i_bus.request = 1'b1; i_bus.addr = 64'h3000;
    tick();
    m_bus.reqack = 1'b1; m_bus.done = 1'b1; m_bus.rdata = pat_e;
    tick();
    m_bus.reqack = 1'b0; m_bus.done = 1'b0;
    n_cmp++; if ({i_bus.reqack, i_bus.done} !== 2'b10) begin
      n_fail++; $display("FAIL stray_issue: got %b expected %b", {i_bus.reqack, i_bus.done}, 2'b10); end
    i_bus.request = 1'b0;
    repeat (2) tick();
    n_cmp++; if (i_bus.done !== 1'b0) begin
      n_fail++; $display("FAIL stray_wait_hold: got %b expected 0", i_bus.done); end
    m_bus.done = 1'b1;
    tick();
    m_bus.done = 1'b0;
    n_cmp++; if ((i_bus.done !== 1'b1) || (i_bus.rdata !== pat_e)) begin
      n_fail++; $display("FAIL stray_done: got %b %h expected 1 %h", i_bus.done, i_bus.rdata, pat_e); end
    tick();
  endtask

  task automatic test_earliest_response();
    logic [1:0] obs;
    i_bus.request = 1'b1; i_bus.addr = 64'h4000;
    tick();
    mem_respond(0, 1, pat_d, 1'b1, obs);
    n_cmp++; if (obs !== 2'b01) begin
      n_fail++; $display("FAIL early_reqack: got %b expected %b", obs, 2'b01); end
    n_cmp++; if ({i_bus.reqack, i_bus.done} !== 2'b01) begin
      n_fail++; $display("FAIL early_sep: got %b expected %b", {i_bus.reqack, i_bus.done}, 2'b01); end
    n_cmp++; if (i_bus.rdata !== pat_d) begin
      n_fail++; $display("FAIL early_rdata: got %h expected %h", i_bus.rdata, pat_d); end
    repeat (2) tick();
    n_cmp++; if (m_bus.request !== 1'b0) begin
      n_fail++; $display("FAIL early_no_regrant: got %b expected 0", m_bus.request); end
  endtask

  task automatic start_both_from_reset();
    reset_n = 1'b0;
    clear_inputs();
    i_bus.request = 1'b1; i_bus.addr = addr_i;
    d_bus.request = 1'b1; d_bus.addr = addr_d;
    tick();
    reset_n = 1'b1;
    tick();
  endtask

`ifdef MEM_ARB_RR_EN
  task automatic test_round_robin();
    logic [1:0] obs;
    logic exp_d;
    start_both_from_reset();
    exp_d = 1'b0;
    n_cmp++; if (m_bus.addr !== addr_i) begin
      n_fail++; $display("FAIL rr_first: got %h expected %h", m_bus.addr, addr_i); end
    for (int k = 0; k < 4; k++) begin
      mem_respond(1, 1, pat_a ^ LW'(k), 1'b0, obs);
      n_cmp++; if (obs !== (exp_d ? 2'b10 : 2'b01)) begin
        n_fail++; $display("FAIL rr_order_%0d: got %b expected %b", k, obs, exp_d ? 2'b10 : 2'b01); end
      tick();
      n_cmp++; if (m_bus.request !== 1'b0) begin
        n_fail++; $display("FAIL rr_gap1_%0d: got %b expected 0", k, m_bus.request); end
      tick();
      exp_d = ~exp_d;
      n_cmp++; if ((m_bus.request !== 1'b1) || (m_bus.addr !== (exp_d ? addr_d : addr_i))) begin
        n_fail++; $display("FAIL rr_gap2_%0d: got req %b addr %h expected 1 %h", k, m_bus.request, m_bus.addr,
          exp_d ? addr_d : addr_i); end
    end
    i_bus.request = 1'b0; d_bus.request = 1'b0;
    mem_respond(1, 1, pat_b, 1'b0, obs);
    repeat (2) tick();
  endtask
`else
  task automatic test_fixed_priority();
    logic [1:0] obs;
    int a0;
    start_both_from_reset();
    a0 = cnt_i_ack;
    for (int k = 0; k < 3; k++) begin
      n_cmp++; if ((m_bus.request !== 1'b1) || (m_bus.addr !== addr_d)) begin
        n_fail++; $display("FAIL fp_grant_%0d: got req %b addr %h expected 1 %h", k, m_bus.request, m_bus.addr, addr_d); end
      mem_respond(1, 2, pat_c ^ LW'(k), 1'b0, obs);
      n_cmp++; if (obs !== 2'b10) begin
        n_fail++; $display("FAIL fp_order_%0d: got %b expected %b", k, obs, 2'b10); end
      if (k == 2) d_bus.request = 1'b0;
      repeat (2) tick();
    end
    n_cmp++; if (cnt_i_ack - a0 !== 0) begin
      n_fail++; $display("FAIL fp_i_starved: got %0d expected 0", cnt_i_ack - a0); end
    n_cmp++; if ((m_bus.request !== 1'b1) || (m_bus.addr !== addr_i)) begin
      n_fail++; $display("FAIL fp_i_after: got req %b addr %h expected 1 %h", m_bus.request, m_bus.addr, addr_i); end
    mem_respond(1, 1, pat_e, 1'b1, obs);
    n_cmp++; if (obs !== 2'b01) begin
      n_fail++; $display("FAIL fp_i_ack: got %b expected %b", obs, 2'b01); end
    repeat (2) tick();
  endtask
`endif

  task automatic test_mid_reset();
    i_bus.request = 1'b1; i_bus.addr = 64'h5000;
    tick();
    m_bus.reqack = 1'b1;
    tick();
    m_bus.reqack = 1'b0;
    i_bus.request = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    n_cmp++; if ({m_bus.request, m_bus.wrenable, i_bus.reqack, i_bus.done, d_bus.reqack, d_bus.done} !== 6'b0) begin
      n_fail++; $display("FAIL mreset_flags: got %b expected 0",
        {m_bus.request, m_bus.wrenable, i_bus.reqack, i_bus.done, d_bus.reqack, d_bus.done}); end
    n_cmp++; if ((m_bus.addr !== '0) || (i_bus.rdata !== '0) || (d_bus.rdata !== '0)) begin
      n_fail++; $display("FAIL mreset_data: got addr %h expected 0", m_bus.addr); end
    clear_inputs();
    reset_n = 1'b1;
    d_bus.request = 1'b1; d_bus.addr = 64'h6040;
    tick();
    n_cmp++; if ((m_bus.request !== 1'b1) || (m_bus.addr !== 64'h6040)) begin
      n_fail++; $display("FAIL mreset_regrant: got req %b addr %h expected 1 %h", m_bus.request, m_bus.addr, 64'h6040); end
    d_bus.request = 1'b0;
    m_bus.reqack = 1'b1; tick(); m_bus.reqack = 1'b0;
    m_bus.done = 1'b1; tick(); m_bus.done = 1'b0;
    n_cmp++; if (d_bus.done !== 1'b1) begin
      n_fail++; $display("FAIL mreset_done: got %b expected 1", d_bus.done); end
    repeat (2) tick();
  endtask

  task automatic test_pulse_exclusion();
    n_cmp++; if (cnt_both !== 0) begin
      n_fail++; $display("FAIL pulse_exclusion: got %0d expected 0", cnt_both); end
  endtask

  initial begin
    pat_a = {16{32'hA5A5_0001}};
    pat_b = {16{32'h0BAD_F00D}};
    pat_c = {16{32'hC3C3_1234}};
    pat_d = {16{32'hDEAD_BEEF}};
    pat_e = {16{32'h1357_9BDF}};
    pat_f = {16{32'hFFFF_0000}};
    addr_i = 64'h0000_0000_0000_7000;
    addr_d = 64'h0000_0000_0000_8040;
    reset_n = 1'b0;
    clear_inputs();

    test_reset();
    test_single_read();
    test_d_write();
    test_stray_response();
    test_earliest_response();
`ifdef MEM_ARB_RR_EN
    test_round_robin();
`else
    test_fixed_priority();
`endif
    test_mid_reset();
    test_pulse_exclusion();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
